// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response bus between EX/MEM and the data memory
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        mem_stall;
    logic        addr_err;
    modport master (output MemRead, MemWrite, addr, wdata, input rdata, rdata_valid, mem_stall, addr_err);
    modport slave (input MemRead, MemWrite, addr, wdata, output rdata, rdata_valid, mem_stall, addr_err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word data memory with programmable wait states and pipeline stall
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W = 8,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [ADDR_W+1:0] a_q;
    logic [31:0] d_q;
    logic rd_q, wr_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic req, do_acc, acc_rd, acc_wr, illegal;
    logic [ADDR_W+1:0] acc_a;
    logic [31:0] acc_d;
    logic [ADDR_W-1:0] idx;
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
    assign req = bus.MemRead | bus.MemWrite;
    // With zero wait states the access happens on the accepting edge, straight from the live inputs
    always_comb begin
        acc_a = state == IDLE ? bus.addr[ADDR_W+1:0] : a_q;
        acc_d = state == IDLE ? bus.wdata : d_q;
        acc_rd = state == IDLE ? bus.MemRead : rd_q;
        acc_wr = state == IDLE ? bus.MemWrite : wr_q;
        idx = acc_a[ADDR_W+1:2];
        illegal = (acc_a[1:0] != 2'b00) || (acc_rd && acc_wr);
        do_acc = !rst && ((state == IDLE && req && WAIT_STATES == 0) || (state == BUSY && cnt == 4'd1));
        bus.mem_stall = !rst && (state == BUSY || (state == IDLE && req));
    end
    always_ff @(posedge clk)
        if (do_acc && acc_wr && !illegal) mem[idx] <= acc_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            bus.rdata <= 32'd0;
            bus.rdata_valid <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.rdata_valid <= do_acc && acc_rd && !illegal;
            bus.addr_err <= do_acc && illegal;
            if (do_acc && acc_rd && !illegal) bus.rdata <= mem[idx];
            case (state)
                IDLE: if (req) begin
                    a_q <= bus.addr[ADDR_W+1:0];
                    d_q <= bus.wdata;
                    rd_q <= bus.MemRead;
                    wr_q <= bus.MemWrite;
                    cnt <= 4'(WAIT_STATES);
                    state <= WAIT_STATES == 0 ? DONE : BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench driving a 2-wait-state and a 0-wait-state responder
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dmem_responder_if b0();
    dmem_responder_if b2();
    dmem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    dmem_responder #(.WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    typedef struct packed {logic err; logic [31:0] d;} exp_t;
    exp_t q0[$];
    exp_t q2[$];
    int passed = 0;
    int total = 0;
    int timeouts = 0;
    int run0 = 0;
    int run2 = 0;
    logic done = 1'b0;
    logic prev_rst = 1'b1;
    logic mem12_chk = 1'b0;
    logic [31:0] mem12_exp = 32'd0;
    logic [31:0] lr0 = 32'd0;
    logic [31:0] lr2 = 32'd0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("stall_in_rst0", 32'(b0.mem_stall), 32'd0);
            chk("stall_in_rst2", 32'(b2.mem_stall), 32'd0);
            run0 = 0;
            run2 = 0;
        end else begin
            if (prev_rst) begin
                chk("rdata_after_rst", b2.rdata, 32'd0);
                chk("pulses_after_rst", 32'({b2.rdata_valid, b2.addr_err}), 32'd0);
                if (mem12_chk) chk("mem12_after_rst", dut2.mem[12], mem12_exp);
            end
            if (b2.mem_stall) run2++;
            else if (run2 != 0) begin
                chk("stall_len2", 32'(run2), 32'd3);
                run2 = 0;
            end
            if (b0.mem_stall) run0++;
            else if (run0 != 0) begin
                chk("stall_len0", 32'(run0), 32'd1);
                run0 = 0;
            end
            if (b2.rdata_valid || b2.addr_err) begin
                if (q2.size() == 0) chk("unexpected_resp2", 32'd1, 32'd0);
                else begin
                    e = q2.pop_front();
                    chk("resp_kind2", 32'({b2.addr_err, b2.rdata_valid}), 32'({e.err, !e.err}));
                    chk("rdata2", b2.rdata, e.d);
                end
            end
            if (b0.rdata_valid || b0.addr_err) begin
                if (q0.size() == 0) chk("unexpected_resp0", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("resp_kind0", 32'({b0.addr_err, b0.rdata_valid}), 32'({e.err, !e.err}));
                    chk("rdata0", b0.rdata, e.d);
                end
            end
            if (done) begin
                chk("pending2", 32'(q2.size()), 32'd0);
                chk("pending0", 32'(q0.size()), 32'd0);
                chk("timeouts", 32'(timeouts), 32'd0);
                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
        end
        prev_rst = rst;
    end

    task automatic idle();
        b0.MemRead = 0; b0.MemWrite = 0; b0.addr = 0; b0.wdata = 0;
        b2.MemRead = 0; b2.MemWrite = 0; b2.addr = 0; b2.wdata = 0;
    endtask

    task automatic acc(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ex, input bit rmid);
        exp_t e;
        logic err;
        bit ok;
        err = (a[1:0] != 2'b00) || (rd && wr);
        e.err = err;
        e.d = err ? (sel ? lr2 : lr0) : ex;
        if (err || rd) begin
            if (sel) q2.push_back(e);
            else q0.push_back(e);
        end
        if (!err && rd) begin
            if (sel) lr2 = ex;
            else lr0 = ex;
        end
        if (sel) begin b2.MemRead = rd; b2.MemWrite = wr; b2.addr = a; b2.wdata = d; end
        else begin b0.MemRead = rd; b0.MemWrite = wr; b0.addr = a; b0.wdata = d; end
        if (rmid) begin
            @(posedge clk); #1 rst = 1'b1;
            lr2 = 32'd0;
            @(posedge clk); #1 rst = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!(sel ? b2.mem_stall : b0.mem_stall)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeouts++;
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        acc(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
        acc(1, 1, 0, 32'h10, 0, 32'hDEADBEEF, 0);
        acc(1, 0, 1, 32'h400, 32'hA5, 0, 0);
        acc(1, 1, 0, 32'h0, 0, 32'hA5, 0);
        acc(1, 1, 0, 32'h402, 32'h1234, 0, 0);
        acc(1, 1, 0, 32'h0, 0, 32'hA5, 0);
        acc(1, 0, 1, 32'h20, 32'h99, 0, 0);
        acc(1, 1, 1, 32'h20, 32'h55, 0, 0);
        acc(1, 1, 0, 32'h20, 0, 32'h99, 0);
        acc(1, 0, 1, 32'h30, 32'h11, 0, 0);
        idle();
        mem12_exp = 32'h11;
        mem12_chk = 1'b1;
        acc(1, 0, 1, 32'h30, 32'h77, 0, 1);
        mem12_chk = 1'b0;
        acc(1, 1, 0, 32'h30, 0, 32'h77, 0);
        idle();
        acc(0, 0, 1, 32'h0, 32'h1, 0, 0);
        acc(0, 0, 1, 32'h4, 32'h2, 0, 0);
        acc(0, 0, 1, 32'h8, 32'h3, 0, 0);
        acc(0, 1, 0, 32'h4, 0, 32'h2, 0);
        acc(0, 1, 0, 32'h0, 0, 32'h1, 0);
        acc(0, 1, 0, 32'h8, 0, 32'h3, 0);
        acc(0, 1, 0, 32'h401, 0, 0, 0);
        idle();
        repeat (3) @(posedge clk);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1);
    end
endmodule
